// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Branch control codes, resolution record and PC increment.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam int c_XLEN = 32;

    localparam logic [3:0] c_BEQ  = 4'b0000;
    localparam logic [3:0] c_BNE  = 4'b0001;
    localparam logic [3:0] c_BLT  = 4'b0100;
    localparam logic [3:0] c_BGE  = 4'b0101;
    localparam logic [3:0] c_BLTU = 4'b0110;
    localparam logic [3:0] c_BGEU = 4'b0111;
    localparam logic [3:0] c_JAL  = 4'b1000;
    localparam logic [3:0] c_JALR = 4'b1001;

    localparam logic [c_XLEN-1:0] c_PC_INC = 32'd4;

    typedef struct packed {
        logic              taken;
        logic [c_XLEN-1:0] next_pc;
        logic [c_XLEN-1:0] link;
        logic              mispredict;
    } resolve_t;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Combinational branch condition, target and mispredict evaluation.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve
    import branch_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 3
) (
    input  logic [C_WIDTH:0] i_control,
    input  logic [WIDTH:0]   i_src1,
    input  logic [WIDTH:0]   i_src2,
    input  logic [WIDTH:0]   i_pc,
    input  logic [WIDTH:0]   i_address,
    input  logic [WIDTH:0]   i_predicted,
    output resolve_t         o_res
);

    // The resolution record is sized by the package; the datapath must match it.
    generate
        if (WIDTH + 1 != c_XLEN) begin : g_width_check
            $error("branch_resolve: WIDTH+1 must equal branch_pkg::c_XLEN");
        end
    endgenerate

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_seq;
    logic [WIDTH:0] w_next;
    logic [WIDTH:0] w_link;
    logic           w_eq;
    logic           w_lt;
    logic           w_ltu;
    logic           w_branch;
    logic           w_jump;
    logic           w_cond;

    always_comb begin
        w_sum    = i_src1 + i_src2;
        w_seq    = i_pc + c_PC_INC[WIDTH:0];
        w_eq     = (i_src1 == i_src2);
        w_lt     = ($signed(i_src1) < $signed(i_src2));
        w_ltu    = (i_src1 < i_src2);
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_cond   = 1'b0;
        w_next   = w_seq;
        w_link   = '0;

        case (i_control)
            c_BEQ:  begin w_branch = 1'b1; w_cond = w_eq;   end
            c_BNE:  begin w_branch = 1'b1; w_cond = !w_eq;  end
            c_BLT:  begin w_branch = 1'b1; w_cond = w_lt;   end
            c_BGE:  begin w_branch = 1'b1; w_cond = !w_lt;  end
            c_BLTU: begin w_branch = 1'b1; w_cond = w_ltu;  end
            c_BGEU: begin w_branch = 1'b1; w_cond = !w_ltu; end
            c_JAL: begin
                w_jump = 1'b1;
                w_next = w_sum;
            end
            c_JALR: begin
                w_jump = 1'b1;
                w_next = w_sum & ~{{WIDTH{1'b0}}, 1'b1};
            end
            default: ;
        endcase

        if (w_branch && w_cond) begin
            w_next = i_address;
        end
        // For jumps issueAddress carries the sequential address, i.e. the link.
        if (w_jump) begin
            w_link = i_address;
        end

        o_res.taken      = w_jump | (w_branch & w_cond);
        o_res.next_pc    = w_next;
        o_res.link       = w_link;
        o_res.mispredict = (w_branch | w_jump) && (w_next != i_predicted);
    end

endmodule : branch_resolve
`default_nettype wire

// File: rtl/branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_exec_unit
// Purpose  : Branch resolve with one-entry CDB output register and redirect.
//            Optional BRANCH_PERF_EN adds resolve/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_exec_unit
    import branch_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issueValid,
    output logic             issueReady,
    input  logic [C_WIDTH:0] issueControl,
    input  logic [ROB:0]     issueRob,
    input  logic [WIDTH:0]   issueSrc1,
    input  logic [WIDTH:0]   issueSrc2,
    input  logic [WIDTH:0]   issuePC,
    input  logic [WIDTH:0]   issueAddress,
    input  logic [WIDTH:0]   issuePredicted,
    input  logic             flush,
    output logic             cdbReq,
    input  logic             cdbGrant,
    output logic [ROB:0]     cdbRob,
    output logic [WIDTH:0]   cdbResult,
    output logic             cdbMispredict,
    output logic             cdbTaken,
`ifdef BRANCH_PERF_EN
    output logic [31:0]      perfResolved,
    output logic [31:0]      perfMispredict,
`endif
    output logic             redirectValid,
    output logic [WIDTH:0]   redirectPC
);

    resolve_t w_res;

    branch_resolve #(
        .WIDTH   (WIDTH),
        .C_WIDTH (C_WIDTH)
    ) u_resolve (
        .i_control   (issueControl),
        .i_src1      (issueSrc1),
        .i_src2      (issueSrc2),
        .i_pc        (issuePC),
        .i_address   (issueAddress),
        .i_predicted (issuePredicted),
        .o_res       (w_res)
    );

    logic           valid_q,  valid_d;
    logic [ROB:0]   rob_q,    rob_d;
    logic [WIDTH:0] result_q, result_d;
    logic [WIDTH:0] npc_q,    npc_d;
    logic           mis_q,    mis_d;
    logic           taken_q,  taken_d;

    logic w_ready;
    logic w_accept;
    logic w_grant;

    always_comb begin
        w_ready  = !valid_q | cdbGrant | flush;
        w_accept = issueValid & w_ready & !flush;
        w_grant  = valid_q & cdbGrant;

        valid_d  = valid_q;
        rob_d    = rob_q;
        result_d = result_q;
        npc_d    = npc_q;
        mis_d    = mis_q;
        taken_d  = taken_q;

        // Flush beats both a same-cycle issue and a pending grant.
        if (flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d  = 1'b1;
            rob_d    = issueRob;
            result_d = w_res.link[WIDTH:0];
            npc_d    = w_res.next_pc[WIDTH:0];
            mis_d    = w_res.mispredict;
            taken_d  = w_res.taken;
        end else if (w_grant) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rob_q    <= '0;
            result_q <= '0;
            npc_q    <= '0;
            mis_q    <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rob_q    <= rob_d;
            result_q <= result_d;
            npc_q    <= npc_d;
            mis_q    <= mis_d;
            taken_q  <= taken_d;
        end
    end

    assign issueReady    = w_ready;
    assign cdbReq        = valid_q;
    assign cdbRob        = rob_q;
    assign cdbResult     = result_q;
    assign cdbMispredict = mis_q;
    assign cdbTaken      = taken_q;
    assign redirectPC    = npc_q;
    assign redirectValid = valid_q & cdbGrant & mis_q & !flush;

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_res_q, perf_res_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    always_comb begin
        perf_res_d = perf_res_q;
        perf_mis_d = perf_mis_q;
        if (w_grant && !flush) begin
            if (perf_res_q != '1) begin
                perf_res_d = perf_res_q + 32'd1;
            end
            if (mis_q && (perf_mis_q != '1)) begin
                perf_mis_d = perf_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_res_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_res_q <= perf_res_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perfResolved   = perf_res_q;
    assign perfMispredict = perf_mis_q;
`endif

endmodule : branch_exec_unit
`default_nettype wire

// File: tb/tb_branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_exec_unit
// Purpose  : Directed table-driven bench for branch_exec_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        issueValid;
    logic        issueReady;
    logic [3:0]  issueControl;
    logic [2:0]  issueRob;
    logic [31:0] issueSrc1, issueSrc2, issuePC, issueAddress, issuePredicted;
    logic        flush;
    logic        cdbReq;
    logic        cdbGrant;
    logic [2:0]  cdbRob;
    logic [31:0] cdbResult;
    logic        cdbMispredict;
    logic        cdbTaken;
    logic        redirectValid;
    logic [31:0] redirectPC;
`ifdef BRANCH_PERF_EN
    logic [31:0] perfResolved;
    logic [31:0] perfMispredict;
`endif

    branch_exec_unit #(.WIDTH(31), .ROB(2), .C_WIDTH(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issueValid     (issueValid),
        .issueReady     (issueReady),
        .issueControl   (issueControl),
        .issueRob       (issueRob),
        .issueSrc1      (issueSrc1),
        .issueSrc2      (issueSrc2),
        .issuePC        (issuePC),
        .issueAddress   (issueAddress),
        .issuePredicted (issuePredicted),
        .flush          (flush),
        .cdbReq         (cdbReq),
        .cdbGrant       (cdbGrant),
        .cdbRob         (cdbRob),
        .cdbResult      (cdbResult),
        .cdbMispredict  (cdbMispredict),
        .cdbTaken       (cdbTaken),
`ifdef BRANCH_PERF_EN
        .perfResolved   (perfResolved),
        .perfMispredict (perfMispredict),
`endif
        .redirectValid  (redirectValid),
        .redirectPC     (redirectPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] s1, s2, pc, addr, pred;
        logic        taken, mis;
        logic [31:0] res, npc;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    int   exp_resolved = 0;
    int   exp_mispred  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_issue(input vec_t v, input logic [2:0] tag);
        issueValid     = 1'b1;
        issueControl   = v.ctrl;
        issueRob       = tag;
        issueSrc1      = v.s1;
        issueSrc2      = v.s2;
        issuePC        = v.pc;
        issueAddress   = v.addr;
        issuePredicted = v.pred;
    endtask

    task automatic check_held(input string name, input vec_t v, input logic [2:0] tag);
        chk({name, ".req"},   {31'd0, cdbReq},        32'd1);
        chk({name, ".taken"}, {31'd0, cdbTaken},      {31'd0, v.taken});
        chk({name, ".mis"},   {31'd0, cdbMispredict}, {31'd0, v.mis});
        chk({name, ".rob"},   {29'd0, cdbRob},        {29'd0, tag});
        chk({name, ".res"},   cdbResult,              v.res);
        chk({name, ".npc"},   redirectPC,             v.npc);
    endtask

    // Grant the held result for one cycle and check the redirect pulse.
    task automatic grant_and_drain(input string name, input vec_t v);
        cdbGrant = 1'b1;
        #1;
        chk({name, ".redir"}, {31'd0, redirectValid}, {31'd0, v.mis});
        exp_resolved++;
        if (v.mis) exp_mispred++;
        @(posedge clk);
        #1;
        cdbGrant = 1'b0;
        chk({name, ".drained"}, {31'd0, cdbReq}, 32'd0);
    endtask

    initial begin
        //          ctrl     s1            s2            pc          addr          pred          tk    mis   res           npc
        vecs[0] = '{4'b0000, 32'd5,        32'd5,        32'h100,    32'h140,      32'h104,      1'b1, 1'b1, 32'h0,        32'h140};
        vecs[1] = '{4'b0100, 32'hFFFFFFFF, 32'd1,        32'h200,    32'h260,      32'h204,      1'b1, 1'b1, 32'h0,        32'h260};
        vecs[2] = '{4'b0110, 32'hFFFFFFFF, 32'd1,        32'h200,    32'h260,      32'h204,      1'b0, 1'b0, 32'h0,        32'h204};
        vecs[3] = '{4'b1001, 32'h1003,     32'h10,       32'h1000,   32'h208,      32'h1012,     1'b1, 1'b0, 32'h208,      32'h1012};
        vecs[4] = '{4'b0001, 32'd5,        32'd5,        32'h300,    32'h380,      32'h380,      1'b0, 1'b1, 32'h0,        32'h304};
        vecs[5] = '{4'b0101, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h400,    32'h480,      32'h480,      1'b1, 1'b0, 32'h0,        32'h480};
        vecs[6] = '{4'b0111, 32'd1,        32'hFFFFFFFF, 32'h500,    32'h540,      32'h540,      1'b0, 1'b1, 32'h0,        32'h504};
        vecs[7] = '{4'b1000, 32'h600,      32'hFFFFFFF0, 32'h600,    32'h604,      32'h604,      1'b1, 1'b1, 32'h604,      32'h5F0};
        vecs[8] = '{4'b0010, 32'd1,        32'd2,        32'h700,    32'h740,      32'h0,        1'b0, 1'b0, 32'h0,        32'h704};
        vecs[9] = '{4'b1000, 32'hFFFFFF00, 32'h200,      32'hFFFFFF00, 32'hFFFFFF04, 32'h100,    1'b1, 1'b0, 32'hFFFFFF04, 32'h100};

        rst_n = 1'b0; issueValid = 1'b0; issueControl = '0; issueRob = '0;
        issueSrc1 = '0; issueSrc2 = '0; issuePC = '0; issueAddress = '0;
        issuePredicted = '0; flush = 1'b0; cdbGrant = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req",   {31'd0, cdbReq},        32'd0);
        chk("rst.ready", {31'd0, issueReady},    32'd1);
        chk("rst.redir", {31'd0, redirectValid}, 32'd0);
        chk("rst.npc",   redirectPC,             32'd0);
        chk("rst.res",   cdbResult,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Grant with nothing held must not produce a broadcast or redirect.
        cdbGrant = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_grant.req",   {31'd0, cdbReq},        32'd0);
        chk("idle_grant.redir", {31'd0, redirectValid}, 32'd0);
        cdbGrant = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_issue(vecs[i], 3'(i));
            @(posedge clk);
            #1;
            issueValid = 1'b0;
            check_held($sformatf("vec%0d", i), vecs[i], 3'(i));
            grant_and_drain($sformatf("vec%0d", i), vecs[i]);
        end

        // Hold for three cycles without grant, then grant with a new issue.
        @(negedge clk);
        drive_issue(vecs[0], 3'd5);
        @(posedge clk);
        #1;
        issueValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d.ready", c), {31'd0, issueReady}, 32'd0);
            check_held($sformatf("hold%0d", c), vecs[0], 3'd5);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        cdbGrant = 1'b1;
        drive_issue(vecs[3], 3'd6);
        #1;
        chk("b2b.ready", {31'd0, issueReady},    32'd1);
        chk("b2b.redir", {31'd0, redirectValid}, 32'd1);
        exp_resolved++;
        exp_mispred++;
        @(posedge clk);
        #1;
        issueValid = 1'b0;
        cdbGrant   = 1'b0;
        check_held("b2b", vecs[3], 3'd6);
        grant_and_drain("b2b", vecs[3]);

        // Flush with grant and a simultaneous issue.
        @(negedge clk);
        drive_issue(vecs[0], 3'd1);
        @(posedge clk);
        #1;
        issueValid = 1'b0;
        @(negedge clk);
        flush = 1'b1; cdbGrant = 1'b1;
        drive_issue(vecs[1], 3'd2);
        #1;
        chk("flush.redir", {31'd0, redirectValid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; cdbGrant = 1'b0; issueValid = 1'b0;
        chk("flush.req", {31'd0, cdbReq}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush.dropped", {31'd0, cdbReq}, 32'd0);

`ifdef BRANCH_PERF_EN
        chk("perf.resolved", perfResolved,   32'(exp_resolved));
        chk("perf.mispred",  perfMispredict, 32'(exp_mispred));
`endif

        // Asynchronous reset while a result is held.
        @(negedge clk);
        drive_issue(vecs[7], 3'd3);
        @(posedge clk);
        #1;
        issueValid = 1'b0;
        chk("prerst.req", {31'd0, cdbReq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.req",   {31'd0, cdbReq},        32'd0);
        chk("arst.ready", {31'd0, issueReady},    32'd1);
        chk("arst.taken", {31'd0, cdbTaken},      32'd0);
        chk("arst.mis",   {31'd0, cdbMispredict}, 32'd0);
        chk("arst.res",   cdbResult,              32'd0);
        chk("arst.npc",   redirectPC,             32'd0);
        chk("arst.rob",   {29'd0, cdbRob},        32'd0);
`ifdef BRANCH_PERF_EN
        chk("arst.perf_res", perfResolved,   32'd0);
        chk("arst.perf_mis", perfMispredict, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst.req", {31'd0, cdbReq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_branch_exec_unit
`default_nettype wire
